// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the data memory MMIO page: register offsets,
// timer control bit positions and the byte-lane merge used by strobed writes.
package mmio_pkg;

    localparam logic [31:0] MMIO_PAGE_MASK = 32'hFFFF_F000;

    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_TCNT = 12'h078;
    localparam logic [11:0] OFF_TCMP = 12'h07C;
    localparam logic [11:0] OFF_TCTL = 12'h080;

    localparam int TCTL_EN     = 0;
    localparam int TCTL_AUTOCLR = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_LED,
        REG_SW,
        REG_TCNT,
        REG_TCMP,
        REG_TCTL
    } mmio_reg_e;

    // Word offset within the page (byte offset bits [11:2]).
    function automatic mmio_reg_e decode_reg(input logic [9:0] word_off);
        mmio_reg_e r;
        r = REG_NONE;
        if (word_off == OFF_LED[11:2])       r = REG_LED;
        else if (word_off == OFF_SW[11:2])   r = REG_SW;
        else if (word_off == OFF_TCNT[11:2]) r = REG_TCNT;
        else if (word_off == OFF_TCMP[11:2]) r = REG_TCMP;
        else if (word_off == OFF_TCTL[11:2]) r = REG_TCTL;
        return r;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;
    logic [W-1:0] stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            stable <= '0;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/mmio_dram.sv
// Data memory for the single-cycle core: word RAM with byte-strobed writes plus
// a 4 KiB MMIO page holding LED, switch and timer registers. Reads are combinational.
module mmio_dram
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 16384,
    parameter int          LED_W     = 24,
    parameter int          SW_W      = 24,
    parameter int          PRESCALE  = 1,
    parameter logic [31:0] MMIO_BASE = 32'hFFFFF000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       adr,
    input  logic [31:0]       wdin,
    input  logic [3:0]        wstrb,
    output logic [31:0]       rd,
    input  logic [SW_W-1:0]   device_sw,
    output logic [LED_W-1:0]  device_led,
    output logic              timer_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic            is_mmio;
    mmio_reg_e       sel;
    logic            wr;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     ram_rd;
    logic [31:0]     mmio_rd;
    logic [SW_W-1:0] sw_sync;

    logic [LED_W-1:0] led_q, led_next;
    logic [31:0]      tcnt, tcnt_next;
    logic [31:0]      tcmp, tcmp_next;
    logic [1:0]       tctl, tctl_next;
    logic [PW-1:0]    pre_cnt, pre_next;
    logic             en, tick, match, match_d, irq_q;

    logic unused_adr;
    assign unused_adr = ^adr[1:0];

    assign is_mmio = (adr & MMIO_PAGE_MASK) == (MMIO_BASE & MMIO_PAGE_MASK);
    assign sel     = is_mmio ? decode_reg(adr[11:2]) : REG_NONE;
    assign wr      = |wstrb;
    assign ram_idx = adr[AW+1:2];

    // Distributed RAM: async read, sync byte-lane write, no reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[ram_idx][8*i +: 8] <= wdin[8*i +: 8];
            end
        end
    end

    assign ram_rd = mem[ram_idx];

    sync2 #(.W(SW_W)) u_sw_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (device_sw),
        .q     (sw_sync)
    );

    assign en    = tctl[TCTL_EN];
    assign tick  = en && (pre_cnt == PRE_LAST);
    assign match = (tcnt == tcmp);

    always_comb begin
        led_next = led_q;
        if (sel == REG_LED) begin
            for (int b = 0; b < LED_W; b++) begin
                if (wstrb[b/8]) led_next[b] = wdin[b];
            end
        end
    end

    // Software write beats auto-clear, which beats the increment.
    always_comb begin
        tcnt_next = tcnt;
        if (sel == REG_TCNT && wr)
            tcnt_next = merge_bytes(tcnt, wdin, wstrb);
        else if (en && match && tctl[TCTL_AUTOCLR])
            tcnt_next = '0;
        else if (tick)
            tcnt_next = tcnt + 32'd1;
    end

    always_comb begin
        tcmp_next = tcmp;
        if (sel == REG_TCMP && wr) tcmp_next = merge_bytes(tcmp, wdin, wstrb);
    end

    always_comb begin
        tctl_next = tctl;
        if (sel == REG_TCTL && wstrb[0]) tctl_next = wdin[1:0];
    end

    always_comb begin
        pre_next = pre_cnt;
        if (!en || tick) pre_next = '0;
        else             pre_next = pre_cnt + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q   <= '0;
            tcnt    <= '0;
            tcmp    <= 32'hFFFF_FFFF;
            tctl    <= '0;
            pre_cnt <= '0;
            match_d <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            led_q   <= led_next;
            tcnt    <= tcnt_next;
            tcmp    <= tcmp_next;
            tctl    <= tctl_next;
            pre_cnt <= pre_next;
            match_d <= match;
            // Rising edge of match only, so a held equality pulses once.
            irq_q   <= match && !match_d;
        end
    end

    always_comb begin
        mmio_rd = '0;
        unique case (sel)
            REG_LED:  mmio_rd = 32'(led_q);
            REG_SW:   mmio_rd = 32'(sw_sync);
            REG_TCNT: mmio_rd = tcnt;
            REG_TCMP: mmio_rd = tcmp;
            REG_TCTL: mmio_rd = {30'd0, tctl};
            default:  mmio_rd = '0;
        endcase
    end

    assign rd         = is_mmio ? mmio_rd : ram_rd;
    assign device_led = led_q;
    assign timer_irq  = irq_q;

endmodule

// File: tb/tb_mmio_dram.sv
// Bench for mmio_dram: vector table through a scoreboard queue, then hand-written
// sequences for switch sync, timer match/auto-clear, write priority and async reset.
module tb_mmio_dram;

    logic        clk;
    logic        rst_n;
    logic [31:0] adr;
    logic [31:0] wdin;
    logic [3:0]  wstrb;
    logic [31:0] rd;
    logic [23:0] device_sw;
    logic [23:0] device_led;
    logic        timer_irq;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wdin;
        logic [3:0]  wstrb;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    mmio_dram #(
        .DEPTH     (16384),
        .LED_W     (24),
        .SW_W      (24),
        .PRESCALE  (1),
        .MMIO_BASE (32'hFFFFF000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adr        (adr),
        .wdin       (wdin),
        .wstrb      (wstrb),
        .rd         (rd),
        .device_sw  (device_sw),
        .device_led (device_led),
        .timer_irq  (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one access at the falling edge; rd is sampled before the next rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                         input bit chk, input logic [31:0] e, input string name);
        sb_t item;
        @(negedge clk);
        adr   = a;
        wdin  = w;
        wstrb = s;
        if (chk) sb_q.push_back('{name, e});
        #1;
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            check(item.name, rd, item.exp);
        end
    endtask

    function automatic void add_vec(input logic [31:0] a, input logic [31:0] w,
                                    input logic [3:0] s, input bit chk, input logic [31:0] e);
        vecs.push_back('{a, w, s, chk, e});
    endfunction

    localparam logic [31:0] A_LED  = 32'hFFFFF060;
    localparam logic [31:0] A_SW   = 32'hFFFFF070;
    localparam logic [31:0] A_TCNT = 32'hFFFFF078;
    localparam logic [31:0] A_TCMP = 32'hFFFFF07C;
    localparam logic [31:0] A_TCTL = 32'hFFFFF080;
    localparam logic [31:0] A_UNM  = 32'hFFFFF0F0;

    logic [31:0] exp_tcnt [9] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1, 32'd2};
    logic        exp_irq  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int irq_pulses;

        add_vec(32'h0000_00F0, 32'hCAFEF00D, 4'b1111, 0, 32'h0);
        add_vec(32'h0000_0060, 32'h11111111, 4'b1111, 0, 32'h0);
        add_vec(32'h0000_0100, 32'hDEADBEEF, 4'b1111, 0, 32'h0);
        add_vec(32'h0000_0100, 32'h0000AA00, 4'b0010, 1, 32'hDEADBEEF);
        add_vec(32'h0000_0100, 32'h0,        4'b0000, 1, 32'hDEADAAEF);
        add_vec(32'h0001_0100, 32'h0,        4'b0000, 1, 32'hDEADAAEF);
        add_vec(A_LED,         32'h00123456, 4'b1111, 1, 32'h0);
        add_vec(A_LED,         32'h0,        4'b0000, 1, 32'h00123456);
        add_vec(32'h0000_0060, 32'h0,        4'b0000, 1, 32'h11111111);
        add_vec(A_LED,         32'hFFFFFFAB, 4'b1001, 1, 32'h00123456);
        add_vec(A_LED,         32'h0,        4'b0000, 1, 32'h001234AB);
        add_vec(A_UNM,         32'h0,        4'b0000, 1, 32'h0);
        add_vec(A_UNM,         32'h12345678, 4'b1111, 1, 32'h0);
        add_vec(A_UNM,         32'h0,        4'b0000, 1, 32'h0);
        add_vec(32'h0000_00F0, 32'h0,        4'b0000, 1, 32'hCAFEF00D);
        add_vec(A_LED,         32'h0,        4'b0000, 1, 32'h001234AB);
        add_vec(A_TCNT,        32'h0,        4'b0000, 1, 32'h0);
        add_vec(A_TCMP,        32'h0,        4'b0000, 1, 32'hFFFFFFFF);
        add_vec(A_TCTL,        32'h0,        4'b0000, 1, 32'h0);
        add_vec(A_TCMP,        32'h00000000, 4'b1110, 1, 32'hFFFFFFFF);
        add_vec(A_TCMP,        32'h00000005, 4'b0001, 1, 32'h000000FF);
        add_vec(A_TCMP,        32'h0,        4'b0000, 1, 32'h00000005);
        add_vec(A_TCTL,        32'hFFFFFFFC, 4'b1111, 1, 32'h0);
        add_vec(A_TCTL,        32'h0,        4'b0000, 1, 32'h0);

        rst_n     = 1'b0;
        adr       = A_TCNT;
        wdin      = '0;
        wstrb     = '0;
        device_sw = 24'h3C3C3C;

        repeat (3) @(negedge clk);
        #1;
        check("rst_led", 32'(device_led), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_tcnt", rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i])
            do_op(vecs[i].adr, vecs[i].wdin, vecs[i].wstrb, vecs[i].chk, vecs[i].exp,
                  $sformatf("vec%0d", i));
        check("led_after_table", 32'(device_led), 32'h001234AB);

        // LED output moves one edge after the store.
        do_op(A_LED, 32'h00654321, 4'b1111, 1, 32'h001234AB, "led_pre_write");
        check("led_out_before_edge", 32'(device_led), 32'h001234AB);
        do_op(A_LED, 32'h0, 4'b0000, 1, 32'h00654321, "led_readback");
        check("led_out_after_edge", 32'(device_led), 32'h00654321);

        // Switch synchroniser: old value after one edge, new after two.
        do_op(A_SW, 32'h0, 4'b0000, 1, 32'h003C3C3C, "sw_settled");
        device_sw = 24'hA5A5A5;
        #1;
        check("sw_same_cycle", rd, 32'h003C3C3C);
        do_op(A_SW, 32'h0, 4'b0000, 1, 32'h003C3C3C, "sw_one_edge");
        do_op(A_SW, 32'h0, 4'b0000, 1, 32'h00A5A5A5, "sw_two_edges");
        do_op(A_SW, 32'hFFFFFFFF, 4'b1111, 1, 32'h00A5A5A5, "sw_write");
        do_op(A_SW, 32'h0, 4'b0000, 1, 32'h00A5A5A5, "sw_write_ignored");

        // Timer with TCMP=5, enable + auto-clear.
        do_op(A_TCTL, 32'h3, 4'b0001, 1, 32'h0, "tctl_old");
        irq_pulses = 0;
        for (int k = 0; k < 9; k++) begin
            do_op(A_TCNT, 32'h0, 4'b0000, 1, exp_tcnt[k], $sformatf("tcnt_seq%0d", k));
            check($sformatf("irq_seq%0d", k), 32'(timer_irq), 32'(exp_irq[k]));
            if (timer_irq) irq_pulses++;
        end
        check("irq_pulse_count", 32'(irq_pulses), 32'd1);

        do_op(A_TCNT, 32'd100, 4'b1111, 1, 32'd3, "tcnt_pre_load");
        do_op(A_TCNT, 32'h0, 4'b0000, 1, 32'd100, "tcnt_write_wins");
        do_op(A_TCNT, 32'h0, 4'b0000, 1, 32'd101, "tcnt_after_load");
        do_op(A_TCTL, 32'h0, 4'b0000, 1, 32'h3, "tctl_running");

        // Asynchronous reset between edges, mid-count.
        @(posedge clk);
        #2;
        adr   = A_TCNT;
        wstrb = '0;
        rst_n = 1'b0;
        #1;
        check("arst_tcnt", rd, 32'h0);
        check("arst_irq", 32'(timer_irq), 32'h0);
        check("arst_led", 32'(device_led), 32'h0);
        adr = A_TCTL;   #1; check("arst_tctl", rd, 32'h0);
        adr = A_LED;    #1; check("arst_led_rd", rd, 32'h0);
        adr = A_TCMP;   #1; check("arst_tcmp", rd, 32'hFFFFFFFF);
        adr = A_SW;     #1; check("arst_sw", rd, 32'h0);
        adr = 32'h100;  #1; check("arst_ram_100", rd, 32'hDEADAAEF);
        adr = 32'h0F0;  #1; check("arst_ram_0f0", rd, 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_op(A_TCNT, 32'h0, 4'b0000, 1, 32'h0, "post_rst_tcnt_frozen");
        do_op(32'h0000_0100, 32'h0, 4'b0000, 1, 32'hDEADAAEF, "post_rst_ram");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mmio_dram.md
# mmio_dram

Parametrised data memory with an integrated memory-mapped I/O window for the single-cycle core. Load/store accesses with addresses in RAM space go to an inferred word array with byte-strobed writes. Accesses in the MMIO page reach three devices: a registered LED register, a synchronised switch input, and a prescaled 32-bit timer. Reads are combinational, which the single-cycle datapath requires; all state updates happen on the rising clock edge.

## Interface
- `DEPTH`, 16384: RAM size in 32-bit words; power of two.
- `LED_W`, 24: LED register width, 1..32.
- `SW_W`, 24: switch input width, 1..32.
- `PRESCALE`, 1: timer increments once every PRESCALE enabled cycles; ≥1.
- `MMIO_BASE`, 32'hFFFFF000: base of the 4 KiB MMIO page.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `adr` in 32: byte address; `adr[1:0]` ignored (word access).
- `wdin` in 32: write data, byte lanes aligned to word.
- `wstrb` in 4: per-byte write strobe; 4'b0000 means read only.
- `rd` out 32: combinational read data.
- `device_sw` in SW_W: raw, asynchronous switch inputs.
- `device_led` out LED_W: registered LED outputs.
- `timer_irq` out 1: one-cycle pulse when the timer equals its compare value.

## Operation
- Decode: `adr[31:12] == MMIO_BASE[31:12]` selects MMIO; any other address selects RAM at word index `adr[$clog2(DEPTH)+1:2]`, so RAM addresses wrap modulo DEPTH.
- RAM: on a clock edge, byte lane i is written when `wstrb[i]` is set and RAM is selected. RAM is never written while MMIO is selected. Contents are not reset.
- MMIO registers (offset within page):
  - 0x060 LED: R/W. Byte-strobed write; bits ≥ LED_W are dropped. Reads return the value zero-extended.
  - 0x070 SW: read only. Returns the 2-flop-synchronised `device_sw`, zero-extended. Writes are ignored.
  - 0x078 TCNT: R/W. Write loads the counter (byte-strobed).
  - 0x07C TCMP: R/W compare value, byte-strobed.
  - 0x080 TCTL: R/W. Bit0 = enable, bit1 = auto-clear on match. Other bits read 0.
- Unmapped MMIO offsets read 32'h0; writes to them are ignored.
- Timer:
  - While enabled, a prescale counter counts 0..PRESCALE-1. TCNT increments on the cycle the prescale counter wraps; TCNT wraps 32'hFFFFFFFF→0.
  - Match: `timer_irq` is high for exactly one cycle, the cycle after TCNT becomes equal to TCMP. If auto-clear is set, TCNT is loaded with 0 on the same edge instead of incrementing further.
  - Disabling the timer freezes TCNT and resets the prescale counter to 0.
- Simultaneous events:
  - A software write to TCNT on the same edge as an increment or auto-clear: the write wins.
  - A write to TCTL on the same edge as a tick: the tick uses the old enable.
  - A write to TCMP on the same edge as a match: the match compares against the old TCMP.

## Timing
- `rd` is valid combinationally from `adr` in the same cycle. An MMIO read returns the register value before the current edge's write.
- A write takes effect at the next rising edge. `device_led` changes one edge after the store.
- SW latency is 2 edges from an input change to visibility in `rd`.
- Reset (asynchronous, may assert at any time, including mid-timer count):
  - `device_led` = 0, TCNT = 0, TCMP = 32'hFFFFFFFF, TCTL = 0, prescale counter = 0, sync flops = 0, `timer_irq` = 0.
  - The RAM array is untouched.
- No handshake: every access completes in one cycle.

## Structure
- Package `mmio_pkg`: MMIO offset constants (LED, SW, TCNT, TCMP, TCTL), TCTL bit positions, and the MMIO page mask.
- Sub-module `sync2` (parametrised width, `clk`/`rst_n`): 2-flop synchroniser for `device_sw`.
- Timer logic stays inline; the RAM is an inferred array (distributed RAM: async read, sync write).

## Test plan
- Store 32'hDEADBEEF to 0x100 with strobe 4'b1111, then strobe 4'b0010 with 32'h0000AA00 → read of 0x100 returns 32'hDEADAAEF; a read of 0x100 + 4×DEPTH returns the same value.
- Store 32'h00123456 to 0xFFFFF060 → `device_led` = 24'h123456 after one edge; RAM word 0x060>>2 is unchanged; reading 0xFFFFF060 returns 32'h00123456.
- `device_sw` changes to 24'hA5A5A5 → reading 0xFFFFF070 returns the old value after 1 edge and 32'h00A5A5A5 after 2 edges; a write to 0xFFFFF070 has no effect.
- PRESCALE=1, TCMP=5, TCTL=2'b11 → TCNT counts 0..5, `timer_irq` pulses once, then TCNT counts 0,1,… again. A TCNT write of 100 coinciding with a tick → TCNT reads 100.
- Assert `rst_n` low mid-count, asynchronously between edges → TCNT, LED, and TCTL read 0 and `timer_irq` = 0 immediately; RAM data written before the reset is still readable.
- Read 0xFFFFF0F0 (unmapped) → returns 0; a write there changes neither RAM nor any device.
